// File: rtl/pipelined_cla_adder.sv
// Pipelined 4-bit-group carry-lookahead adder with 1/2/4 lane precision.
// Optional macro CLA_OVERFLOW_DETECT_EN adds per-lane signed overflow.
module pipelined_cla_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [3:0]       cout,
    output logic [3:0]       ovf
);
    localparam int NG = WIDTH / 4;

    // 4-bit lookahead group: {carry out, carry into bit 3, sum}
    function automatic logic [5:0] cla4(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       ci
    );
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | ((&p) & ci);
        return {c[4], c[3], p ^ c[3:0]};
    endfunction

    // Groups per lane for a (reserved-folded) mode
    function automatic int lane_groups(input logic [1:0] m);
        case (m)
            2'b01:   return NG / 2;
            2'b10:   return NG / 4;
            default: return NG;
        endcase
    endfunction

    logic [STAGES-1:0] v_q;
    logic [WIDTH-1:0]  a_q  [STAGES];
    logic [WIDTH-1:0]  b_q  [STAGES];
    logic [WIDTH-1:0]  s_q  [STAGES];
    logic              c_q  [STAGES];
    logic [1:0]        m_q  [STAGES];
    logic [3:0]        ci_q [STAGES];
    logic [3:0]        co_q [STAGES];

    logic [STAGES-1:0] v_i;
    logic [WIDTH-1:0]  a_i  [STAGES];
    logic [WIDTH-1:0]  b_i  [STAGES];
    logic [WIDTH-1:0]  s_i  [STAGES];
    logic              c_i  [STAGES];
    logic [1:0]        m_i  [STAGES];
    logic [3:0]        ci_i [STAGES];
    logic [3:0]        co_i [STAGES];

    logic [WIDTH-1:0]  s_o  [STAGES];
    logic              c_o  [STAGES];
    logic [3:0]        co_o [STAGES];

`ifdef CLA_OVERFLOW_DETECT_EN
    logic [3:0]        ov_q [STAGES];
    logic [3:0]        ov_i [STAGES];
    logic [3:0]        ov_o [STAGES];
`endif

    logic [STAGES-1:0] ld;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = k * NG / STAGES;
        localparam int HI = (k + 1) * NG / STAGES;

        // A stage loads when it or any later stage holds a bubble,
        // or when the output is being drained.
        assign ld[k] = out_ready || !(&v_q[STAGES-1:k]);

        if (k == 0) begin : g_src
            assign v_i[k]  = in_valid;
            assign a_i[k]  = a;
            assign b_i[k]  = b;
            assign s_i[k]  = '0;
            assign c_i[k]  = 1'b0;
            assign m_i[k]  = mode;
            assign ci_i[k] = cin;
            assign co_i[k] = '0;
`ifdef CLA_OVERFLOW_DETECT_EN
            assign ov_i[k] = '0;
`endif
        end else begin : g_src
            assign v_i[k]  = v_q[k-1];
            assign a_i[k]  = a_q[k-1];
            assign b_i[k]  = b_q[k-1];
            assign s_i[k]  = s_q[k-1];
            assign c_i[k]  = c_q[k-1];
            assign m_i[k]  = m_q[k-1];
            assign ci_i[k] = ci_q[k-1];
            assign co_i[k] = co_q[k-1];
`ifdef CLA_OVERFLOW_DETECT_EN
            assign ov_i[k] = ov_q[k-1];
`endif
        end

        logic [WIDTH-1:0] so;
        logic [3:0]       coo;
        logic             cr;
        logic [1:0]       m;
        logic [1:0]       ln;
        logic [5:0]       r;
        int               len;
`ifdef CLA_OVERFLOW_DETECT_EN
        logic [3:0]       ovo;
`endif

        // Group carry chain over this stage's slice; lane starts take cin
        always_comb begin
            so  = s_i[k];
            coo = co_i[k];
            cr  = c_i[k];
            m   = (m_i[k] == 2'b11) ? 2'b00 : m_i[k];
            len = lane_groups(m);
            ln  = '0;
            r   = '0;
`ifdef CLA_OVERFLOW_DETECT_EN
            ovo = ov_i[k];
`endif
            for (int g = LO; g < HI; g++) begin
                ln = 2'(g / len);
                if ((g % len) == 0) cr = ci_i[k][ln];
                r = cla4(a_i[k][4*g +: 4], b_i[k][4*g +: 4], cr);
                so[4*g +: 4] = r[3:0];
                cr = r[5];
                if ((g % len) == len - 1) begin
                    coo[ln] = r[5];
`ifdef CLA_OVERFLOW_DETECT_EN
                    ovo[ln] = r[5] ^ r[4];
`endif
                end
            end
        end

        assign s_o[k]  = so;
        assign c_o[k]  = cr;
        assign co_o[k] = coo;
`ifdef CLA_OVERFLOW_DETECT_EN
        assign ov_o[k] = ovo;
`endif
    end

    // Stage registers; payload only updates when a valid item arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= '0;
                b_q[k]  <= '0;
                s_q[k]  <= '0;
                c_q[k]  <= 1'b0;
                m_q[k]  <= '0;
                ci_q[k] <= '0;
                co_q[k] <= '0;
`ifdef CLA_OVERFLOW_DETECT_EN
                ov_q[k] <= '0;
`endif
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    v_q[k] <= v_i[k];
                    if (v_i[k]) begin
                        a_q[k]  <= a_i[k];
                        b_q[k]  <= b_i[k];
                        s_q[k]  <= s_o[k];
                        c_q[k]  <= c_o[k];
                        m_q[k]  <= m_i[k];
                        ci_q[k] <= ci_i[k];
                        co_q[k] <= co_o[k];
`ifdef CLA_OVERFLOW_DETECT_EN
                        ov_q[k] <= ov_o[k];
`endif
                    end
                end
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = co_q[STAGES-1];
`ifdef CLA_OVERFLOW_DETECT_EN
    assign ovf       = ov_q[STAGES-1];
`else
    assign ovf       = 4'b0000;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder, WIDTH=16, STAGES=2.
// Expected values are hand-computed constants and simple counters.
module tb_pipelined_cla_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mode;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic [3:0]  cout;
    logic [3:0]  ovf;

    int n_cmp = 0;
    int n_err = 0;

    pipelined_cla_adder #(.WIDTH(16), .STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction through an idle pipe with out_ready=1
    task automatic run_one(input string tag, input logic [1:0] m,
                           input logic [15:0] x, input logic [15:0] y,
                           input logic [3:0] ci, input logic [15:0] es,
                           input logic [3:0] ec, input logic [3:0] eo);
        mode = m; a = x; b = y; cin = ci;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_lat"}, {31'd0, out_valid}, 32'd0);
        step();
        check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
        check({tag, "_cout"}, {28'd0, cout}, {28'd0, ec});
        check({tag, "_ovf"}, {28'd0, ovf}, {28'd0, eo});
        step();
    endtask

    logic [3:0] ovf_exp;
    int         sent;
    int         got;
    int         exp_sum;
    int         seen;
    logic       acc;
    logic       ret;

    initial begin
`ifdef CLA_OVERFLOW_DETECT_EN
        ovf_exp = 4'b0001;
`else
        ovf_exp = 4'b0000;
`endif
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        mode = 2'b00; a = 16'h1234; b = 16'h4321; cin = 4'b0000;
        step();
        step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {28'd0, cout}, 32'd0);
        check("rst_ovf", {28'd0, ovf}, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        step();

        run_one("full", 2'b00, 16'hFFFF, 16'h0001, 4'b0000,
                16'h0000, 4'b0001, 4'b0000);
        run_one("half", 2'b01, 16'h00FF, 16'h0001, 4'b0000,
                16'h0000, 4'b0001, 4'b0000);
        run_one("quart", 2'b10, 16'hFFFF, 16'h1110, 4'b0001,
                16'h0000, 4'b1111, 4'b0000);
        run_one("half_cin", 2'b01, 16'h0000, 16'h0000, 4'b0011,
                16'h0101, 4'b0000, 4'b0000);
        run_one("mode11", 2'b11, 16'hFFFF, 16'h0001, 4'b1110,
                16'h0000, 4'b0001, 4'b0000);
        run_one("ovf", 2'b00, 16'h7FFF, 16'h0001, 4'b0000,
                16'h8000, 4'b0000, ovf_exp);

        // Backpressure: out_ready low for 4 edges
        out_ready = 1'b0; in_valid = 1'b1; mode = 2'b00;
        b = 16'h0001; cin = 4'b0000; a = 16'd0;
        step();
        check("bp_ready_1", {31'd0, in_ready}, 32'd1);
        a = 16'd1;
        step();
        check("bp_ready_drop", {31'd0, in_ready}, 32'd0);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_sum_first", {16'd0, sum}, 32'd1);
        a = 16'd2;
        step();
        check("bp_hold_a", {16'd0, sum}, 32'd1);
        check("bp_ready_a", {31'd0, in_ready}, 32'd0);
        step();
        check("bp_hold_b", {16'd0, sum}, 32'd1);
        check("bp_ready_b", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        sent = 2; got = 0; exp_sum = 1;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            #1;
            acc = in_valid && in_ready;
            ret = out_valid && out_ready;
            if (ret) begin
                check("bp_order", {16'd0, sum}, 32'(exp_sum));
                exp_sum++;
                got++;
            end
            step();
            if (acc) begin
                sent++;
                if (sent < 6) a = 16'(sent);
                else in_valid = 1'b0;
            end
        end
        check("bp_count", 32'(got), 32'd6);
        in_valid = 1'b0;
        step();

        // Fill, stall, then reset mid-flight
        out_ready = 1'b0; in_valid = 1'b1;
        a = 16'h0100; b = 16'h0000;
        step();
        a = 16'h0200;
        step();
        check("mr_full", {31'd0, out_valid}, 32'd1);
        rst = 1'b1; in_valid = 1'b0;
        step();
        rst = 1'b0;
        check("mr_out_valid", {31'd0, out_valid}, 32'd0);
        check("mr_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        seen = 0;
        repeat (5) begin
            step();
            if (out_valid) seen++;
        end
        check("mr_no_stale", 32'(seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder built from 4-bit lookahead groups.
- Supports run-time selectable precision: one full-width lane, two half-width lanes, or four quarter-width lanes. Carries never cross a lane boundary.
- Sits in the datapath of the variable precision multiplier as the partial-product final adder.
- Uses a valid/ready handshake on both sides so it can stall under downstream backpressure.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 16 (so every quarter lane is a whole number of 4-bit groups); minimum 16.
- STAGES, 2, number of pipeline register stages (latency); legal range 1..WIDTH/4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand transaction valid.
- in_ready  output  1  block can accept a transaction this cycle.
- mode  input  2  precision select: 00 = 1×WIDTH, 01 = 2×WIDTH/2, 10 = 4×WIDTH/4, 11 = reserved (treated as 00).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  4  per-lane carry-in; bit i feeds lane i; bits beyond the active lane count are ignored.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  lane-wise sum; lane i occupies bits [(i+1)L-1 : iL], where L = WIDTH >> mode.
- cout  output  4  per-lane carry-out; bits beyond the active lane count read 0.
- ovf  output  4  per-lane signed overflow (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clock edge): every stage valid bit is cleared, and sum, cout and ovf registers go to 0. On the following cycle out_valid=0 and in_ready=1. rst overrides in_valid on the same edge, and in-flight data is discarded.
- Transfer rule: a transfer occurs when valid && ready are both high at a rising edge, on both ports.
- Pipeline advance: stage k advances when stage k+1 is empty or stage k+1 is itself advancing. The last stage advances on out_ready, or whenever it is empty.
- in_ready = !stage0_valid || stage0_advancing. It is combinational from out_ready through the stage chain; there is no skid buffer.
- Latency: with no stall, a transaction accepted at edge n produces out_valid=1 with its result after edge n+STAGES-1. Throughput is 1 per cycle.
- Stall: while out_valid=1 && out_ready=0, the outputs sum, cout and ovf hold stable. No transaction is lost or reordered. At most STAGES transactions are in flight.
- Per-transaction mode: mode and cin are captured with a and b and travel with them. Mode may change every transaction.
- Arithmetic: within each lane, {cout[i], lane sum} = a_lane + b_lane + cin[i], i.e. an unsigned (L+1)-bit result.
- Lane isolation: the group carry into the first 4-bit group of each lane is cin[i]. The carry out of the top group of the lane goes only to cout[i].
- Pipeline partitioning: the group-level carry chain is split across stages at 4-bit group boundaries. Generate/propagate are computed per group, and lookahead is applied within each stage's slice. Inter-stage carry and the not-yet-summed operand bits are registered.
- Mode 11: behaves exactly as mode 00, and cout[3:1]=0.
- Empty pipeline: out_valid=0. The sum/cout/ovf registers keep their last values; they are don't-care for checking, but must not go X after reset.
- Simultaneous accept and emit: on a single edge the block may accept a new input and retire the output. Occupancy is unchanged.

Optional Feature:
- Macro: CLA_OVERFLOW_DETECT_EN.
- Defined: ovf[i] = carry into lane i MSB XOR carry out of lane i MSB, i.e. two's-complement overflow. It is registered and pipelined with its sum. Bits for inactive lanes read 0.
- Not defined: ovf is tied to 4'b0000, and no overflow logic is synthesised.

Test Plan:
- Reset: WIDTH=16, STAGES=2; hold rst=1 for 2 cycles with in_valid=1 → out_valid=0, in_ready=1, sum=0, cout=0, ovf=0.
- Full width: mode=00, a=16'hFFFF, b=16'h0001, cin=0, out_ready=1 → 2 cycles later sum=16'h0000, cout=4'b0001.
- Half lanes: mode=01, a=16'h00FF, b=16'h0001, cin=0 → sum=16'h0000, cout=4'b0001. The carry does not enter the upper lane.
- Quarter lanes with carry-in: mode=10, a=16'hFFFF, b=16'h1110, cin=4'b0001 → sum=16'h0000, cout=4'b1111.
- Backpressure: issue 6 back-to-back transactions (a=i, b=1, i=0..5, mode=00) while holding out_ready=0 for 4 cycles.
  - in_ready drops after 2 accepts, and the held output is stable.
  - After release, sums 1..6 emerge in order with none lost.
- Overflow and mid-flight reset:
  - mode=00, a=16'h7FFF, b=16'h0001 → ovf=4'b0001 with CLA_OVERFLOW_DETECT_EN defined, 4'b0000 without.
  - Then fill the pipeline, hold out_ready=0, and pulse rst → next cycle out_valid=0, and no pre-reset result appears afterwards.
